dcp_stream_sequencer: RTL

- Parametrised two-pass AXI4-Stream frame sequencer for the DCP haze-removal pipeline. It sits between the DMA-facing stream ports and the processing core (window generator + ALE + TE/SRSC).
- Pass 1 feeds a frame to the core for atmospheric-light estimation. Pass 2 feeds the next frame for recovery and forwards results through an output FIFO.
- Adds behaviour the single-pass top level lacks: real backpressure, TLAST generation, per-pass interrupts, frame counting, TLAST error checking, and data-path clock enables instead of gated clocks.

---
 rtl/dcp_stream_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dcp_stream_sequencer.sv
// Two-pass AXI4-Stream frame sequencer for the DCP haze-removal core.
// Pass 1 (ALE) streams a frame into the core for atmospheric-light estimation.
// Pass 2 (TE) streams the next frame for recovery. Its results return through
// an output FIFO.
// Intake is credit-limited so that every in-flight result has a FIFO slot.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              run enable; low stalls intake
//   s_tdata/tvalid/tlast/tready    input stream (tlast is checked only)
//   core_in_data/valid  registered pixel strobe to the core
//   pass_ale_en/te_en   data-path clock enables for ALE and TE/SRSC
//   ale_done_in         level from ALE: estimate ready
//   core_out_data/valid core results (no backpressure)
//   m_tdata/tvalid/tlast/tready    output stream
//   irq_clear           clears err_tlast
//   intr_ale/intr_frame 1-cycle interrupt pulses
//   err_tlast           sticky input TLAST mismatch
//   frame_count         completed recovered frames, wraps at 16 bits
module dcp_stream_sequencer #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 512,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          REESTIMATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_valid,
  output logic              pass_ale_en,
  output logic              pass_te_en,
  input  logic              ale_done_in,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic              irq_clear,
  output logic              intr_ale,
  output logic              intr_frame,
  output logic              err_tlast,
  output logic [15:0]       frame_count
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned PixW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  // Wide enough for fifo_count + inflight without overflow.
  localparam int unsigned CntW = PtrW + 2;
  localparam logic [PixW-1:0] LastPix = PixW'(NPIX - 1);

  typedef enum logic [2:0] {StIdle, StAlePass, StWaitAle, StTePass, StDrain} state_e;

  state_e            state_q;
  logic [PixW-1:0]   in_cnt_q, out_cnt_q;
  logic [CntW-1:0]   fifo_count_q, fifo_count_d, inflight_q, inflight_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              last_popped_q;
  logic              accept, te_accept, push, pop, in_last, credit_ok, drain_done;

  always_comb begin
    accept       = s_tvalid & s_tready;
    te_accept    = accept & (state_q == StTePass);
    push         = core_out_valid & ((state_q == StTePass) | (state_q == StDrain));
    pop          = m_tvalid & m_tready;
    in_last      = (in_cnt_q == LastPix);
    fifo_count_d = fifo_count_q + CntW'(push) - CntW'(pop);
    inflight_d   = inflight_q + CntW'(te_accept) - CntW'(push);
    // s_tready is registered, so credit is judged on next-cycle occupancy.
    credit_ok    = (fifo_count_d + inflight_d) < CntW'(FIFO_DEPTH);
    drain_done   = (inflight_q == '0) & (fifo_count_q == '0) & last_popped_q;
  end

  assign m_tvalid = (fifo_count_q != '0);
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid & (out_cnt_q == LastPix);

  // Output FIFO bookkeeping and in-flight credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      inflight_q   <= '0;
      out_cnt_q    <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        out_cnt_q <= (out_cnt_q == LastPix) ? '0 : out_cnt_q + PixW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= core_out_data;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      s_tready      <= 1'b0;
      pass_ale_en   <= 1'b0;
      pass_te_en    <= 1'b0;
      intr_ale      <= 1'b0;
      intr_frame    <= 1'b0;
      frame_count   <= '0;
      in_cnt_q      <= '0;
      last_popped_q <= 1'b0;
      err_tlast     <= 1'b0;
      core_in_valid <= 1'b0;
      core_in_data  <= '0;
    end else begin
      intr_ale      <= 1'b0;
      intr_frame    <= 1'b0;
      core_in_valid <= accept;
      if (accept) begin
        core_in_data <= s_tdata;
        in_cnt_q     <= in_last ? '0 : in_cnt_q + PixW'(1);
      end
      // Set wins over a simultaneous clear.
      err_tlast <= (accept & (s_tlast != in_last)) | (err_tlast & ~irq_clear);
      if (pop && m_tlast) last_popped_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q     <= StAlePass;
            pass_ale_en <= 1'b1;
            s_tready    <= 1'b1;
          end
        end
        StAlePass: begin
          s_tready <= enable;
          if (accept && in_last) begin
            state_q  <= StWaitAle;
            s_tready <= 1'b0;
          end
        end
        StWaitAle: begin
          if (ale_done_in) begin
            state_q     <= StTePass;
            intr_ale    <= 1'b1;
            pass_ale_en <= 1'b0;
            pass_te_en  <= 1'b1;
            s_tready    <= enable & credit_ok;
          end
        end
        StTePass: begin
          s_tready <= enable & credit_ok;
          if (te_accept && in_last) begin
            state_q  <= StDrain;
            s_tready <= 1'b0;
          end
        end
        StDrain: begin
          if (drain_done) begin
            frame_count   <= frame_count + 16'd1;
            intr_frame    <= 1'b1;
            last_popped_q <= 1'b0;
            if (REESTIMATE) begin
              state_q     <= StAlePass;
              pass_te_en  <= 1'b0;
              pass_ale_en <= 1'b1;
              s_tready    <= enable;
            end else begin
              state_q  <= StTePass;
              s_tready <= enable & credit_ok;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          s_tready    <= 1'b0;
          pass_ale_en <= 1'b0;
          pass_te_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule
